// File: rtl/slave_port.sv
// rtl/slave_port.sv - serial-bus slave port bridging bit-serial master transfers to word memory strobes
//
// Purpose: receives a serial address, burst length and (for writes) data words
// LSB first, then issues one-cycle memory write/read strobes per word. Read
// words are returned to the master serially, LSB first, qualified by s_valid.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   sel, read_en, write_en      slave select and transaction mode
//   m_valid                     master serial bit valid
//   addr_bus, burst_size_bus,
//   w_data_bus                  serial address / burst length / write data
//   s_ready                     slave idle
//   s_valid, r_data_bus         serial read data and its valid
//   mem_addr, mem_wdata         memory address and write word
//   mem_we, mem_re              one-cycle memory strobes
//   mem_rdata, mem_rvalid       memory read word and its valid
module slave_port #(
    parameter int WORD_SIZE       = 8,
    parameter int SLAVE_ADDR_SIZE = 12,
    parameter int BURST_SIZE      = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sel,
    input  logic                       read_en,
    input  logic                       write_en,
    input  logic                       m_valid,
    input  logic                       addr_bus,
    input  logic                       burst_size_bus,
    input  logic                       w_data_bus,
    output logic                       s_ready,
    output logic                       s_valid,
    output logic                       r_data_bus,
    output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]       mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    input  logic [WORD_SIZE-1:0]       mem_rdata,
    input  logic                       mem_rvalid
);

    localparam int MAX_AB = (SLAVE_ADDR_SIZE > BURST_SIZE) ? SLAVE_ADDR_SIZE : BURST_SIZE;
    localparam int MAX_W  = (MAX_AB > WORD_SIZE) ? MAX_AB : WORD_SIZE;
    localparam int CNT_W  = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, BURST, WDATA, WRITE, RREQ, RWAIT, RDATA
    } state_t;

    state_t                     state_q, state_d;
    logic                       is_read_q, is_read_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SLAVE_ADDR_SIZE-1:0] addr_q, addr_d;
    // Holds the serially received burst length, then the remaining word count.
    logic [BURST_SIZE-1:0]      burst_q, burst_d;
    logic [WORD_SIZE-1:0]       wsh_q, wsh_d;
    logic [WORD_SIZE-1:0]       rsh_q, rsh_d;

    logic                       s_ready_d, s_valid_d, r_data_d, mem_we_d, mem_re_d;
    logic [SLAVE_ADDR_SIZE-1:0] mem_addr_d;
    logic [WORD_SIZE-1:0]       mem_wdata_d;

    logic                       last_addr, last_burst, last_word, last_txn;
    logic [BURST_SIZE-1:0]      burst_in;

    assign last_addr  = (bit_cnt_q == CNT_W'(SLAVE_ADDR_SIZE - 1));
    assign last_burst = (bit_cnt_q == CNT_W'(BURST_SIZE - 1));
    assign last_word  = (bit_cnt_q == CNT_W'(WORD_SIZE - 1));
    assign last_txn   = (burst_q == BURST_SIZE'(1));
    assign burst_in   = {burst_size_bus, burst_q[BURST_SIZE-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (sel && (read_en ^ write_en)) state_d = ADDR;
            ADDR:  if (!sel) state_d = IDLE;
                   else if (m_valid && last_addr) state_d = BURST;
            BURST: if (!sel) state_d = IDLE;
                   else if (m_valid && last_burst) state_d = is_read_q ? RREQ : WDATA;
            WDATA: if (!sel) state_d = IDLE;
                   else if (m_valid && last_word) state_d = WRITE;
            // The write strobe is already out; sel only decides whether to continue.
            WRITE: state_d = (!sel || last_txn) ? IDLE : WDATA;
            RREQ:  state_d = sel ? RWAIT : IDLE;
            RWAIT: if (!sel) state_d = IDLE;
                   else if (mem_rvalid) state_d = RDATA;
            RDATA: if (!sel) state_d = IDLE;
                   else if (last_word) state_d = last_txn ? IDLE : RREQ;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values, all derived from state_d so
    // every output is a flop that already reflects the state being entered.
    always_comb begin
        is_read_d   = is_read_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        wsh_d       = wsh_q;
        rsh_d       = rsh_q;
        mem_wdata_d = mem_wdata_q_hold();
        r_data_d    = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (state_d == ADDR) is_read_d = read_en;
            end
            ADDR: if (sel && m_valid) begin
                addr_d    = {addr_bus, addr_q[SLAVE_ADDR_SIZE-1:1]};
                bit_cnt_d = last_addr ? '0 : bit_cnt_q + CNT_W'(1);
            end
            BURST: if (sel && m_valid) begin
                burst_d   = (last_burst && burst_in == '0) ? BURST_SIZE'(1) : burst_in;
                bit_cnt_d = last_burst ? '0 : bit_cnt_q + CNT_W'(1);
            end
            WDATA: if (sel && m_valid) begin
                wsh_d     = {w_data_bus, wsh_q[WORD_SIZE-1:1]};
                bit_cnt_d = last_word ? '0 : bit_cnt_q + CNT_W'(1);
                if (last_word) mem_wdata_d = wsh_d;
            end
            WRITE: begin
                addr_d  = addr_q + SLAVE_ADDR_SIZE'(1);
                burst_d = burst_q - BURST_SIZE'(1);
            end
            RWAIT: if (sel && mem_rvalid) begin
                r_data_d  = mem_rdata[0];
                rsh_d     = mem_rdata >> 1;
                bit_cnt_d = '0;
            end
            RDATA: if (sel) begin
                if (last_word) begin
                    bit_cnt_d = '0;
                    addr_d    = addr_q + SLAVE_ADDR_SIZE'(1);
                    burst_d   = burst_q - BURST_SIZE'(1);
                end else begin
                    r_data_d  = rsh_q[0];
                    rsh_d     = rsh_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        s_ready_d  = (state_d == IDLE);
        s_valid_d  = (state_d == RDATA);
        mem_we_d   = (state_d == WRITE);
        mem_re_d   = (state_d == RREQ);
        mem_addr_d = (state_d == WRITE || state_d == RREQ) ? addr_d : mem_addr;
    end

    function automatic logic [WORD_SIZE-1:0] mem_wdata_q_hold();
        return mem_wdata;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_read_q  <= 1'b0;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            wsh_q      <= '0;
            rsh_q      <= '0;
            s_ready    <= 1'b1;
            s_valid    <= 1'b0;
            r_data_bus <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            is_read_q  <= is_read_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            wsh_q      <= wsh_d;
            rsh_q      <= rsh_d;
            s_ready    <= s_ready_d;
            s_valid    <= s_valid_d;
            r_data_bus <= r_data_d;
            mem_we     <= mem_we_d;
            mem_re     <= mem_re_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_slave_port.sv
// tb/tb_slave_port.sv - self-checking bench for slave_port
module tb_slave_port;

    logic        clk = 1'b0;
    logic        rst_n, sel, read_en, write_en, m_valid;
    logic        addr_bus, burst_size_bus, w_data_bus;
    logic        s_ready, s_valid, r_data_bus, mem_we, mem_re, mem_rvalid;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    slave_port dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .read_en(read_en), .write_en(write_en),
        .m_valid(m_valid), .addr_bus(addr_bus), .burst_size_bus(burst_size_bus),
        .w_data_bus(w_data_bus), .s_ready(s_ready), .s_valid(s_valid),
        .r_data_bus(r_data_bus), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [11:0] addr;
        logic [11:0] burst;
        int          gap;
        logic [7:0]  d0, d1;
        int          nwords;
        logic [11:0] a0, a1;
        int          lat;
    } vec_t;

    vec_t vecs[5];
    int   n_cmp = 0, n_err = 0, cyc = 0, run = 0, start_cyc = 0;

    logic [11:0] we_addr[$], re_addr[$];
    logic [7:0]  we_data[$], rdq[$];
    int          we_cyc[$], runs[$];
    logic        bits[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
            we_cyc.push_back(cyc);
        end
        if (mem_re) re_addr.push_back(mem_addr);
        if (s_valid) begin
            bits.push_back(r_data_bus);
            run++;
        end else if (run != 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (mem_re && rdq.size() > 0) begin
                @(posedge clk); #2;
                mem_rvalid = 1'b1;
                mem_rdata  = rdq.pop_front();
                @(posedge clk); #2;
                mem_rvalid = 1'b0;
                mem_rdata  = 8'h00;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        we_addr.delete(); we_data.delete(); we_cyc.delete();
        re_addr.delete(); runs.delete(); bits.delete();
        run = 0;
    endtask

    // bus: 0 address, 1 burst, 2 write data; idle buses carry the inverted bit.
    task automatic send_field(input logic [11:0] val, input int n, input int bus,
                              input int gap, input int gap_at);
        logic b;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i == gap_at) begin
                m_valid = 1'b0;
                repeat (gap) step();
            end
            b = val[i];
            m_valid        = 1'b1;
            addr_bus       = (bus == 0) ? b : ~b;
            burst_size_bus = (bus == 1) ? b : ~b;
            w_data_bus     = (bus == 2) ? b : ~b;
            step();
        end
        m_valid = 1'b0;
    endtask

    task automatic start_txn(input bit rd);
        sel = 1'b1; read_en = rd; write_en = ~rd;
        step();
        start_cyc = cyc;
        read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && !s_ready; i++) step();
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]  words[2];
        logic [11:0] addrs[2];
        logic [7:0]  w;
        words[0] = v.d0; words[1] = v.d1;
        addrs[0] = v.a0; addrs[1] = v.a1;
        clear_mon();
        rdq.delete();
        if (v.rd) begin
            rdq.push_back(v.d0);
            rdq.push_back(v.d1);
        end
        start_txn(v.rd);
        send_field(v.addr, 12, 0, v.gap, 3);
        send_field(v.burst, 12, 1, 0, 0);
        if (!v.rd) begin
            for (int k = 0; k < v.nwords; k++) begin
                send_field({4'h0, words[k]}, 8, 2, 0, 0);
                step();
            end
        end
        wait_idle(300);
        step();
        chk("s_ready_after", s_ready, 1);
        if (!v.rd) begin
            chk("we_count", we_addr.size(), v.nwords);
            for (int k = 0; k < v.nwords && k < we_addr.size(); k++) begin
                chk("we_addr", we_addr[k], addrs[k]);
                chk("we_data", we_data[k], words[k]);
            end
            if (we_cyc.size() > 0) chk("we_latency", we_cyc[0] - start_cyc, v.lat);
            chk("no_re_on_write", re_addr.size(), 0);
        end else begin
            chk("re_count", re_addr.size(), v.nwords);
            for (int k = 0; k < v.nwords && k < re_addr.size(); k++)
                chk("re_addr", re_addr[k], addrs[k]);
            chk("rbit_count", bits.size(), v.nwords * 8);
            chk("run_count", runs.size(), v.nwords);
            for (int k = 0; k < runs.size(); k++) chk("s_valid_run", runs[k], 8);
            for (int k = 0; k < v.nwords; k++) begin
                w = 8'h00;
                for (int b = 0; b < 8; b++)
                    if (k * 8 + b < bits.size()) w[b] = bits[k * 8 + b];
                chk("rd_word", w, words[k]);
            end
            chk("no_we_on_read", we_addr.size(), 0);
        end
    endtask

    initial begin
        vecs[0] = '{0, 12'h105, 12'd1, 0, 8'hA9, 8'h00, 1, 12'h105, 12'h000, 32};
        vecs[1] = '{1, 12'hFFF, 12'd2, 0, 8'h3C, 8'hC3, 2, 12'hFFF, 12'h000, -1};
        vecs[2] = '{0, 12'h2A7, 12'd0, 0, 8'h5A, 8'h00, 1, 12'h2A7, 12'h000, 32};
        vecs[3] = '{0, 12'h0F0, 12'd1, 5, 8'h33, 8'h00, 1, 12'h0F0, 12'h000, 37};
        vecs[4] = '{0, 12'hFFF, 12'd2, 0, 8'h11, 8'h22, 2, 12'hFFF, 12'h000, 32};

        sel = 0; read_en = 0; write_en = 0; m_valid = 0;
        addr_bus = 0; burst_size_bus = 0; w_data_bus = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_r_data", r_data_bus, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // both modes requested: must stay idle
        clear_mon();
        sel = 1; read_en = 1; write_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("both_en_idle", s_ready, 1);
        end
        read_en = 0; write_en = 0;
        step();
        chk("both_en_no_strobe", we_addr.size() + re_addr.size(), 0);

        // sel dropped mid-WDATA: abort without write strobe
        clear_mon();
        start_txn(0);
        send_field(12'h123, 12, 0, 0, 0);
        send_field(12'd1, 12, 1, 0, 0);
        send_field(12'h0FF, 3, 2, 0, 0);
        sel = 0;
        step();
        chk("abort_idle", s_ready, 1);
        repeat (10) step();
        chk("abort_no_we", we_addr.size(), 0);
        sel = 1;

        // reset pulsed during RDATA
        clear_mon();
        rdq.delete();
        rdq.push_back(8'h55);
        rdq.push_back(8'hAA);
        start_txn(1);
        send_field(12'h010, 12, 0, 0, 0);
        send_field(12'd2, 12, 1, 0, 0);
        for (int i = 0; i < 20 && !s_valid; i++) step();
        chk("rd_reached_rdata", s_valid, 1);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_s_valid", s_valid, 0);
        chk("rst_mid_s_ready", s_ready, 1);
        chk("rst_mid_mem_addr", mem_addr, 0);
        step(); step();
        rst_n = 1'b1;
        clear_mon();
        repeat (20) step();
        chk("rst_mid_no_re", re_addr.size(), 0);
        chk("rst_mid_no_rbits", bits.size(), 0);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 8, data word width; SLAVE_ADDR_SIZE, default 12, address width; BURST_SIZE, default 12, burst-length field width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sel  input  1  this slave selected by bus decoder.
REQ-005 read_en / write_en  input  1 each  transaction mode from master.
REQ-006 m_valid  input  1  master serial bit valid this cycle.
REQ-007 addr_bus / burst_size_bus / w_data_bus  input  1 each  serial address, burst length and write-data bits, LSB first.
REQ-008 s_ready  output  1  slave idle, can accept a transaction.
REQ-009 s_valid  output  1  r_data_bus carries a valid read bit.
REQ-010 r_data_bus  output  1  serial read data to master, LSB first.
REQ-011 mem_addr  output  SLAVE_ADDR_SIZE  and  mem_wdata  output  WORD_SIZE  memory address and write word.
REQ-012 mem_we / mem_re  output  1 each  one-cycle memory write / read strobes.
REQ-013 mem_rdata  input  WORD_SIZE  and  mem_rvalid  input  1  memory read word and its valid.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, BURST, WDATA, WRITE, RREQ, RWAIT, RDATA.
REQ-015 In IDLE, sel=1 with exactly one of read_en/write_en high SHALL latch the mode and go to ADDR; both high or both low SHALL leave the FSM in IDLE.
REQ-016 ADDR, BURST and WDATA SHALL shift in one bit per cycle only while m_valid=1; m_valid=0 SHALL hold the shift register and bit counter.
REQ-017 After SLAVE_ADDR_SIZE address bits the FSM SHALL go to BURST; after BURST_SIZE burst bits it SHALL go to WDATA (write) or RREQ (read).
REQ-018 A received burst length of 0 SHALL be treated as 1.
REQ-019 After WORD_SIZE data bits WDATA SHALL go to WRITE; WRITE SHALL assert mem_we for exactly one cycle with mem_addr = current address and mem_wdata = assembled word.
REQ-020 With m_valid held high, mem_we SHALL be high in the cycle following the 32nd rising edge after the edge that accepted the start (default parameters).
REQ-021 RREQ SHALL assert mem_re for exactly one cycle, then enter RWAIT; RWAIT SHALL capture mem_rdata on the first cycle mem_rvalid=1 and go to RDATA.
REQ-022 RDATA SHALL drive s_valid=1 for WORD_SIZE consecutive cycles, r_data_bus = bit 0 first; s_valid SHALL be 0 in every other state.
REQ-023 After each word the remaining count SHALL decrement and the address SHALL increment modulo 2^SLAVE_ADDR_SIZE (0xFFF+1 -> 0x000); count 0 -> IDLE, else WDATA (write) or RREQ (read).
REQ-024 sel=0 in ADDR, BURST, WDATA, RREQ, RWAIT or RDATA SHALL abort to IDLE next cycle with no further mem_we/mem_re; WRITE SHALL complete its strobe, then go to IDLE.
REQ-025 s_ready SHALL be 1 only in IDLE.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE: s_ready=1, s_valid=0, r_data_bus=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, counters and shift registers 0.
REQ-028 Reset asserted mid-transaction SHALL discard the partial transaction with no memory strobe after rst_n rises.

Verification
REQ-029 Write, addr 0x105, burst 1, data 0xA9, m_valid constant -> single mem_we, mem_addr=0x105, mem_wdata=0xA9, timing per REQ-020, then s_ready=1.
REQ-030 Read, addr 0xFFF, burst 2, mem returns 0x3C then 0xC3 -> mem_re at 0xFFF then 0x000; serial out 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1, s_valid high 8 cycles each.
REQ-031 Write, burst 0, data 0x5A -> exactly one mem_we (addr as sent, data 0x5A).
REQ-032 m_valid low 5 cycles mid-ADDR -> address still assembled correctly; mem_we delayed exactly 5 cycles.
REQ-033 read_en=write_en=1 with sel=1 -> stays IDLE, s_ready=1; sel dropped mid-WDATA -> IDLE, no mem_we.
REQ-034 rst_n pulsed low during RDATA -> s_valid=0 at once, no further mem_re; next write transaction completes normally.
